spi_deserializer: RTL and testbench
===================================

Name: spi_deserializer

Overview:
Receive-side counterpart of the FIFO-fed SPI serializer: the SPI target that samples an incoming sclk/mosi stream (MSB first, SPI mode 0) framed by an active-low chip select. It assembles DATA_WIDTH-bit words and pushes each completed word into a downstream FIFO through a single-cycle write strobe. Sits between the SPI pins and the RX FIFO's write port, entirely in the clk domain; all SPI inputs are asynchronous and are synchronized internally.

Parameters:
DATA_WIDTH, 8, word width in bits; one FIFO write per word.
SYNC_STAGES, 2, flop stages on each of sclk, mosi and cs_n (minimum 2).
BIT_COUNTER_WIDTH, $clog2(DATA_WIDTH), width of the bit counter (derived; not overridden).

Ports:
clk  input  1  system clock; every flop sits in this domain.
rst  input  1  reset, synchronous, active-low: sampled only on posedge clk, asserted when 0.
sclk  input  1  SPI clock from the initiator, asynchronous.
mosi  input  1  serial data, asynchronous, valid around sclk rising edge.
cs_n  input  1  frame select, active low, asynchronous.
full  input  1  RX FIFO full flag.
write_en  output  1  one-cycle FIFO push strobe.
write_data  output  DATA_WIDTH  assembled word, MSB = first bit received.
busy  output  1  high while state != IDLE.
overflow  output  1  one-cycle pulse: word completed while full=1; word dropped.
frame_err  output  1  one-cycle pulse: cs_n released with a partial word.

Behaviour:
- Reset (rst=0 at posedge clk): state=IDLE, shift_reg=0, write_data=0, bit_counter=DATA_WIDTH-1, write_en=0, overflow=0, frame_err=0, busy=0. Synchronizer chains reset to sclk=0, mosi=0, cs_n=1.
- Reset mid-frame: the partial word is discarded, no write_en is issued, and the block waits in IDLE for a new cs_n falling edge. A cs_n already low when reset releases does not start a frame.
- Synchronizers and edge detection: sclk_rise = synced sclk is 1 and the previous synced value is 0. Same construction for cs_fall and cs_rise. mosi is sampled from its synced copy in the same cycle as sclk_rise.
- Pin-to-sample latency is SYNC_STAGES+1 clk cycles. Supported sclk frequency is at most clk/4, with each sclk phase at least 2 clk periods.
- FSM states: IDLE, SHIFT, STORE.
- IDLE:
  - cs_fall -> SHIFT, with bit_counter=DATA_WIDTH-1.
  - sclk edges are ignored.
- SHIFT:
  - On sclk_rise: shift_reg <= {shift_reg[DATA_WIDTH-2:0], mosi_s}.
  - If bit_counter==0, go to STORE next cycle; otherwise decrement bit_counter by 1.
  - On cs_rise with bit_counter != DATA_WIDTH-1: frame_err=1 for one cycle, go to IDLE, discard shift_reg.
  - On cs_rise with bit_counter == DATA_WIDTH-1: go to IDLE, no error.
  - cs_rise and sclk_rise in the same cycle: cs_rise wins and the sample is discarded.
- STORE lasts exactly one cycle:
  - Decide on the full value seen in that cycle.
  - If full=0: write_en=1 and write_data=shift_reg, both registered, so they appear the cycle after STORE.
  - If full=1: overflow=1 for one cycle, no write_en, write_data unchanged.
  - Next state is SHIFT (reload bit_counter=DATA_WIDTH-1 for a back-to-back word) if synced cs_n=0; otherwise IDLE.
- write_en is never high for two consecutive cycles.
- write_data holds its value until the next successful store.
- write_en and overflow are mutually exclusive.
- busy=1 in SHIFT and STORE.

Test Plan:
- Reset: hold rst=0 for 3 clk with cs_n=0 and sclk toggling -> all outputs 0, busy=0. After release, no activity until cs_n rises then falls.
- Single word: cs_n=0, send 8'hA5 MSB first at clk/8, full=0 -> exactly one write_en pulse with write_data=8'hA5, ≤SYNC_STAGES+3 clk after the 8th sclk rise. Then busy=0 after cs_n=1.
- Back-to-back words: one frame carrying 8'h3C then 8'hC3 -> two write_en pulses, data 3C then C3, no frame_err.
- Overflow: full=1 during STORE of 8'hFF -> overflow pulse for 1 cycle, no write_en, write_data keeps its previous value. Next word 8'h01 with full=0 is written normally.
- Aborted frame: cs_n=0, 5 sclk rises, cs_n=1 -> frame_err pulse for 1 cycle, no write_en. A following full 8'h5A frame writes 8'h5A.
- Mid-frame reset: 4 bits in, rst=0 for 1 clk -> no write_en; next frame 8'h81 is received correctly.

Source files
------------

// File: rtl/spi_deserializer.sv
// SPI mode-0 target receiver: synchronizes sclk/mosi/cs_n into clk, assembles
// MSB-first words and pushes each completed word into an RX FIFO.
module spi_deserializer #(
    parameter int  DATA_WIDTH        = 8,
    parameter int  SYNC_STAGES       = 2,
    localparam int BIT_COUNTER_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  cs_n,
    input  logic                  full,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  busy,
    output logic                  overflow,
    output logic                  frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STORE = 2'd2
    } state_t;

    localparam logic [BIT_COUNTER_WIDTH-1:0] CNT_MAX = BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);
    localparam int WARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic [WARM_W-1:0]      warm_q;
    logic                   armed_q;

    state_t                        state_q, state_d;
    logic [DATA_WIDTH-1:0]         shift_q, shift_d;
    logic [DATA_WIDTH-1:0]         wdata_q, wdata_d;
    logic [BIT_COUNTER_WIDTH-1:0]  cnt_q, cnt_d;
    logic                          wen_q, wen_d;
    logic                          ovf_q, ovf_d;
    logic                          ferr_q, ferr_d;
    logic                          busy_q, busy_d;

    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, cs_fall, cs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    // Input synchronizers, edge history and post-reset arming.
    // A frame may only start after cs_n has been seen high with real pin samples,
    // so a cs_n held low through reset cannot fake a falling edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            warm_q      <= '0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            if (warm_q != WARM_DONE) begin
                warm_q <= warm_q + WARM_W'(1);
            end else if (cs_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Next-state logic for the receive FSM and its registered outputs.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        wen_d   = 1'b0;
        ovf_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_MAX;
                    shift_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // cs_rise takes priority over a coincident sclk sample.
                if (cs_rise) begin
                    state_d = IDLE;
                    shift_d = '0;
                    ferr_d  = (cnt_q != CNT_MAX);
                    cnt_d   = CNT_MAX;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (cnt_q == '0) begin
                        state_d = STORE;
                    end else begin
                        cnt_d = cnt_q - BIT_COUNTER_WIDTH'(1);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            STORE: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    wen_d   = 1'b1;
                    wdata_d = shift_q;
                end
                cnt_d   = CNT_MAX;
                state_d = cs_s ? IDLE : SHIFT;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_MAX;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            wdata_q <= '0;
            cnt_q   <= CNT_MAX;
            wen_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign write_en   = wen_q;
    assign write_data = wdata_q;
    assign busy       = busy_q;
    assign overflow   = ovf_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_spi_deserializer.sv
// Randomized bench for spi_deserializer: drives SPI frames and compares the
// observed FIFO-side event stream against a word-level reference model.
module tb_spi_deserializer;

    localparam int DW   = 8;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          cs_n = 1'b1;
    logic          full = 1'b0;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic          busy;
    logic          overflow;
    logic          frame_err;

    spi_deserializer #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .full       (full),
        .write_en   (write_en),
        .write_data (write_data),
        .busy       (busy),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rise_cyc = 0;
    int lat_last = 0;
    logic prev_wen = 1'b0;
    // Events encoded as kind*256 + data: 0 = write, 1 = overflow, 2 = frame error.
    int exp_q[$];
    int obs_q[$];
    logic [DW-1:0] exp_last = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observed event monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (write_en) begin
            chk("wen_consecutive", {31'd0, prev_wen}, 32'd0);
            chk("wen_ovf_exclusive", {31'd0, overflow}, 32'd0);
            obs_q.push_back(int'(write_data));
            lat_last = cyc - last_rise_cyc;
        end
        if (overflow)  obs_q.push_back(256 + int'(write_data));
        if (frame_err) obs_q.push_back(512);
        prev_wen = write_en;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sbit(input logic b, input int half);
        mosi = b;
        tick(half);
        sclk = 1'b1;
        last_rise_cyc = cyc;
        tick(half);
        sclk = 1'b0;
    endtask

    // Sends the top nbits of v; the model records the outcome of complete words.
    task automatic send_word(input logic [DW-1:0] v, input int nbits, input logic f, input int half);
        full = f;
        for (int i = DW - 1; i >= DW - nbits; i--) sbit(v[i], half);
        tick(4);
        if (nbits == DW) begin
            if (f) begin
                exp_q.push_back(256 + int'(exp_last));
            end else begin
                exp_q.push_back(int'(v));
                exp_last = v;
            end
        end
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic frame_end(input logic partial);
        tick(2);
        cs_n = 1'b1;
        if (partial) exp_q.push_back(512);
        tick(8);
        full = 1'b0;
    endtask

    task automatic compare(input string tag);
        int n;
        tick(4);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int nw, tail, half;
        logic [DW-1:0] v;

        // Reset held with cs_n low and sclk toggling.
        rst  = 1'b0;
        cs_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            sclk = ~sclk;
        end
        chk("rst_write_en", {31'd0, write_en}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_write_data", {24'd0, write_data}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mosi = 1'($urandom_range(0, 1));
            sclk = ~sclk;
            tick(2);
        end
        sclk = 1'b0;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        compare("post_rst_events");
        cs_n = 1'b1;
        tick(6);

        // Single word at clk/8.
        frame_begin();
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        send_word(8'hA5, DW, 1'b0, 4);
        chk("latency_ok", {31'd0, (lat_last <= SYNC + 3)}, 32'd1);
        frame_end(1'b0);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);
        compare("single");

        // Back-to-back words in one frame.
        frame_begin();
        send_word(8'h3C, DW, 1'b0, 3);
        send_word(8'hC3, DW, 1'b0, 2);
        frame_end(1'b0);
        compare("b2b");

        // Overflow then normal write.
        frame_begin();
        send_word(8'hFF, DW, 1'b1, 2);
        send_word(8'h01, DW, 1'b0, 2);
        frame_end(1'b0);
        chk("ovf_then_data", {24'd0, write_data}, 32'h01);
        compare("overflow");

        // Aborted frame then a good one.
        frame_begin();
        send_word(8'hB7, 5, 1'b0, 2);
        frame_end(1'b1);
        frame_begin();
        send_word(8'h5A, DW, 1'b0, 2);
        frame_end(1'b0);
        compare("abort");

        // Reset in the middle of a frame.
        frame_begin();
        send_word(8'hF0, 4, 1'b0, 2);
        rst = 1'b0;
        tick(1);
        rst  = 1'b1;
        cs_n = 1'b1;
        exp_last = '0;
        tick(8);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_data", {24'd0, write_data}, 32'd0);
        compare("midrst");
        frame_begin();
        send_word(8'h81, DW, 1'b0, 2);
        frame_end(1'b0);
        compare("after_midrst");

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            nw   = $urandom_range(1, 3);
            tail = ($urandom_range(0, 9) < 3) ? $urandom_range(1, DW - 1) : 0;
            frame_begin();
            for (int w = 0; w < nw; w++) begin
                v    = DW'($urandom);
                half = $urandom_range(2, 4);
                send_word(v, DW, ($urandom_range(0, 3) == 0), half);
            end
            if (tail != 0) begin
                v = DW'($urandom);
                send_word(v, tail, 1'b0, 2);
            end
            frame_end(tail != 0);
            compare("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
